// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush control for load-use, branch redirect and multi-cycle EX ops
module hazard_ctrl #(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             ex_md_start,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_we,
    output logic             idex_flush,
    output logic             exmem_we,
    output logic             exmem_flush,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);
    localparam int MW = $clog2(MD_LATENCY);
    typedef enum logic {RUN, MD_WAIT} state_t;
    state_t state, next_state;
    logic [MW-1:0] md_cnt;
    logic lu, branch, freeze, bubble;
    assign lu = ex_mem_read && ex_rd != 5'd0 &&
                ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    // state, md down-counter and busy flag; md_busy mirrors the registered state
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state   <= RUN;
            md_cnt  <= '0;
            md_busy <= 1'b0;
        end else begin
            state   <= next_state;
            md_busy <= next_state == MD_WAIT;
            md_cnt  <= (state == RUN && next_state == MD_WAIT) ? MW'(MD_LATENCY - 2) :
                       (state == MD_WAIT && md_cnt != '0) ? md_cnt - 1'b1 : md_cnt;
        end
    end
    // saturating event counters
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            stall_count <= (!pc_we && stall_count != '1) ? stall_count + 1'b1 : stall_count;
            flush_count <= (branch && flush_count != '1) ? flush_count + 1'b1 : flush_count;
        end
    end
    // next state: branch beats md in RUN; MD_WAIT leaves once the countdown reaches zero
    always_comb begin
        next_state = state;
        if (state == RUN)
            next_state = (!ex_branch_taken && ex_md_start) ? MD_WAIT : RUN;
        else
            next_state = (md_cnt == '0) ? RUN : MD_WAIT;
    end
    // output decode: release cycle of MD_WAIT falls through to default controls
    always_comb begin
        branch      = state == RUN && ex_branch_taken;
        freeze      = (state == RUN && !ex_branch_taken && ex_md_start) ||
                      (state == MD_WAIT && md_cnt != '0);
        bubble      = state == RUN && !ex_branch_taken && !ex_md_start && lu;
        pc_we       = !(freeze || bubble);
        ifid_we     = !(freeze || bubble);
        ifid_flush  = branch;
        idex_we     = !freeze;
        idex_flush  = branch || bubble;
        exmem_we    = 1'b1;
        exmem_flush = freeze;
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vector table plus md, reset and saturation sequences
module tb_hazard_ctrl;
    logic clk = 1'b0, rst = 1'b1;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0, ex_mem_read = 1'b0, ex_branch_taken = 1'b0, ex_md_start = 1'b0;
    logic pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, exmem_flush, md_busy;
    logic [31:0] stall_count, flush_count;
    logic s_pc_we, s_ifid_we, s_ifid_flush, s_idex_we, s_idex_flush, s_exmem_we, s_exmem_flush, s_md_busy;
    logic [3:0] s_stall_count, s_flush_count;
    int checks = 0, errors = 0;
    int es = 0, ef = 0;
    localparam logic [6:0] DEF = 7'b1101010, BUB = 7'b0001110, BR = 7'b1111110, FRZ = 7'b0000011;
    typedef struct {
        logic [4:0] rs1, rs2;
        logic u1, u2;
        logic [4:0] rd;
        logic mr, bt, md;
        logic [6:0] exp;
    } vec_t;
    vec_t v[9];
    wire [6:0] outs = {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, exmem_flush};

    hazard_ctrl #(.MD_LATENCY(4), .CNT_W(32)) u_dut (
        .Clk(clk), .Rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1),
        .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_branch_taken(ex_branch_taken), .ex_md_start(ex_md_start), .pc_we(pc_we),
        .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_we(idex_we), .idex_flush(idex_flush),
        .exmem_we(exmem_we), .exmem_flush(exmem_flush), .md_busy(md_busy),
        .stall_count(stall_count), .flush_count(flush_count));

    hazard_ctrl #(.MD_LATENCY(4), .CNT_W(4)) u_sat (
        .Clk(clk), .Rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1),
        .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_branch_taken(ex_branch_taken), .ex_md_start(ex_md_start), .pc_we(s_pc_we),
        .ifid_we(s_ifid_we), .ifid_flush(s_ifid_flush), .idex_we(s_idex_we), .idex_flush(s_idex_flush),
        .exmem_we(s_exmem_we), .exmem_flush(s_exmem_flush), .md_busy(s_md_busy),
        .stall_count(s_stall_count), .flush_count(s_flush_count));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t x);
        id_rs1 = x.rs1; id_rs2 = x.rs2; id_uses_rs1 = x.u1; id_uses_rs2 = x.u2;
        ex_rd = x.rd; ex_mem_read = x.mr; ex_branch_taken = x.bt; ex_md_start = x.md;
    endtask

    task automatic idle();
        apply('{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, DEF});
    endtask

    task automatic post_edge_counts(input logic busy);
        @(posedge clk); #1;
        chk("stall_count", stall_count, es);
        chk("flush_count", flush_count, ef);
        chk("md_busy", {31'd0, md_busy}, {31'd0, busy});
    endtask

    initial begin
        v[0] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, DEF};
        v[1] = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, BUB};
        v[2] = '{5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, DEF};
        v[3] = '{5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, DEF};
        v[4] = '{5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, BUB};
        v[5] = '{5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, DEF};
        v[6] = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, BR};
        v[7] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, BR};
        v[8] = '{5'd4, 5'd9, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, DEF};
        #1;
        chk("rst_outs", {25'd0, outs}, {25'd0, DEF});
        chk("rst_stall", stall_count, 0);
        chk("rst_flush", flush_count, 0);
        chk("rst_busy", {31'd0, md_busy}, 0);
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk); apply(v[i]); #1;
            chk($sformatf("vec%0d_outs", i), {25'd0, outs}, {25'd0, v[i].exp});
            es += v[i].exp[6] ? 0 : 1;
            ef += v[i].exp[4] ? 1 : 0;
            post_edge_counts(1'b0);
        end
        // md op held in EX: three freezes then a release cycle
        @(negedge clk); idle(); ex_md_start = 1'b1; #1;
        chk("md_f1_outs", {25'd0, outs}, {25'd0, FRZ});
        chk("md_f1_busy", {31'd0, md_busy}, 0);
        es++; post_edge_counts(1'b1);
        @(negedge clk); #1;
        chk("md_f2_outs", {25'd0, outs}, {25'd0, FRZ});
        es++; post_edge_counts(1'b1);
        @(negedge clk); ex_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd5;
        id_rs1 = 5'd5; id_uses_rs1 = 1'b1; #1;
        chk("md_f3_ignore_br", {25'd0, outs}, {25'd0, FRZ});
        es++; post_edge_counts(1'b1);
        @(negedge clk); idle(); ex_md_start = 1'b1; #1;
        chk("md_release_outs", {25'd0, outs}, {25'd0, DEF});
        post_edge_counts(1'b0);
        @(negedge clk); idle(); #1;
        chk("md_after_outs", {25'd0, outs}, {25'd0, DEF});
        // reset asserted during the 2nd MD_WAIT cycle
        ex_md_start = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk("pre_rst_busy", {31'd0, md_busy}, 1);
        chk("pre_rst_outs", {25'd0, outs}, {25'd0, FRZ});
        #2; rst = 1'b1; ex_md_start = 1'b0; #1;
        chk("rst_mid_busy", {31'd0, md_busy}, 0);
        chk("rst_mid_pc_we", {31'd0, pc_we}, 1);
        chk("rst_mid_stall", stall_count, 0);
        chk("rst_mid_flush", flush_count, 0);
        @(negedge clk); rst = 1'b0; es = 0; ef = 0;
        // 20 back-to-back load-use stalls; 4-bit counter saturates at 15
        @(negedge clk); apply(v[1]);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (i == 14 || i == 15 || i == 19) begin
                chk($sformatf("sat_stall_%0d", i), {28'd0, s_stall_count}, (i + 1 > 15) ? 15 : i + 1);
                chk($sformatf("wide_stall_%0d", i), stall_count, i + 1);
            end
        end
        @(negedge clk); idle(); #1;
        chk("sat_flush", {28'd0, s_flush_count}, 0);
        chk("end_outs", {25'd0, outs}, {25'd0, DEF});
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
